// File: rtl/litepcie_rq_pkg.sv
// Shared constants for the LitePCIe legacy-TLP to UltraScale RQ request adapter.
package litepcie_rq_pkg;

  localparam logic [7:0] FmtTypeMrd32 = 8'b000_00000;
  localparam logic [7:0] FmtTypeMrd64 = 8'b001_00000;
  localparam logic [7:0] FmtTypeMwr32 = 8'b010_00000;
  localparam logic [7:0] FmtTypeMwr64 = 8'b011_00000;

  localparam logic [3:0] ReqTypeMrd = 4'b0000;
  localparam logic [3:0] ReqTypeMwr = 4'b0001;

  localparam logic [2:0] StHdr   = 3'd0;
  localparam logic [2:0] StPass  = 3'd1;
  localparam logic [2:0] StShift = 3'd2;
  localparam logic [2:0] StFlush = 3'd3;
  localparam logic [2:0] StDrop  = 3'd4;

  localparam int unsigned DescAddrLsb    = 2;
  localparam int unsigned DescDwCntLsb   = 64;
  localparam int unsigned DescReqTypeLsb = 75;
  localparam int unsigned DescEpBit      = 79;
  localparam int unsigned DescReqIdLsb   = 80;
  localparam int unsigned DescTagLsb     = 96;
  localparam int unsigned DescRidEnBit   = 120;
  localparam int unsigned DescTcLsb      = 121;
  localparam int unsigned DescAttrLsb    = 124;

  // Legacy length field encodes 1024 DW as zero.
  function automatic logic [10:0] len_to_dw(input logic [9:0] len);
    return {(len == 10'd0), len};
  endfunction

  function automatic logic [3:0] dw_keep(input logic [10:0] rem);
    if (rem >= 11'd4) return 4'hF;
    return (4'b0001 << rem[1:0]) - 4'b0001;
  endfunction

endpackage

// File: rtl/rq_desc_build.sv
// Combinational mapping of a legacy TLP header beat onto an RQ descriptor.
module rq_desc_build
  import litepcie_rq_pkg::*;
(
  input  logic [127:0] hdr_i,
  output logic [127:0] desc_o,
  output logic [3:0]   first_be_o,
  output logic [3:0]   last_be_o,
  output logic [10:0]  dw_cnt_o,
  output logic         is_read_o,
  output logic         is_write_o,
  output logic         is_4dw_o
);

  logic [7:0]  fmt_type;
  logic [3:0]  req_type;
  logic [61:0] addr;

  always_comb begin
    fmt_type   = hdr_i[31:24];
    is_read_o  = (fmt_type == FmtTypeMrd32) || (fmt_type == FmtTypeMrd64);
    is_write_o = (fmt_type == FmtTypeMwr32) || (fmt_type == FmtTypeMwr64);
    is_4dw_o   = hdr_i[29];
    req_type   = is_write_o ? ReqTypeMwr : ReqTypeMrd;
    dw_cnt_o   = len_to_dw(hdr_i[9:0]);
    first_be_o = hdr_i[35:32];
    last_be_o  = hdr_i[39:36];
    // 4DW headers carry the upper address in DW2 and the lower in DW3.
    addr = is_4dw_o ? {hdr_i[95:64], hdr_i[127:98]} : {32'b0, hdr_i[95:66]};

    desc_o                           = '0;
    desc_o[DescAddrLsb +: 62]        = addr;
    desc_o[DescDwCntLsb +: 11]       = dw_cnt_o;
    desc_o[DescReqTypeLsb +: 4]      = req_type;
    desc_o[DescEpBit]                = hdr_i[14];
    desc_o[DescReqIdLsb +: 16]       = hdr_i[63:48];
    desc_o[DescTagLsb +: 8]          = hdr_i[47:40];
    desc_o[DescRidEnBit]             = 1'b1;
    desc_o[DescTcLsb +: 3]           = hdr_i[22:20];
    desc_o[DescAttrLsb +: 2]         = hdr_i[13:12];
  end

  logic unused_hdr;
  assign unused_hdr = ^{hdr_i[11:10], hdr_i[19:15], hdr_i[23], hdr_i[97:96]};

endmodule

// File: rtl/s_axis_rq_adapt.sv
// Legacy LitePCIe request TLP stream to UltraScale s_axis_rq descriptor stream.
module s_axis_rq_adapt
  import litepcie_rq_pkg::*;
#(
  parameter int DATA_WIDTH = 128,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  user_clk,
  input  logic                  user_reset,
  input  logic [DATA_WIDTH-1:0] s_axis_rq_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_rq_tkeep,
  input  logic                  s_axis_rq_tlast,
  output logic                  s_axis_rq_tready,
  input  logic                  s_axis_rq_tvalid,
  output logic [DATA_WIDTH-1:0] s_axis_rq_tdata_a,
  output logic [3:0]            s_axis_rq_tkeep_a,
  output logic                  s_axis_rq_tlast_a,
  input  logic [3:0]            s_axis_rq_tready_a,
  output logic [59:0]           s_axis_rq_tuser_a,
  output logic                  s_axis_rq_tvalid_a
);

  logic [2:0]            state_q, state_d;
  logic [10:0]           rem_q, rem_d, rem_next;
  logic [31:0]           carry_q, carry_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic [3:0]            tkeep_q, tkeep_d;
  logic                  tlast_q, tlast_d;
  logic [59:0]           tuser_q, tuser_d;
  logic                  tvalid_q, tvalid_d;

  logic                  can_load, in_ready, in_fire;
  logic [127:0]          desc;
  logic [3:0]            first_be, last_be;
  logic [10:0]           dw_cnt;
  logic                  is_read, is_write, is_4dw;

  rq_desc_build u_desc_build (
    .hdr_i      (s_axis_rq_tdata),
    .desc_o     (desc),
    .first_be_o (first_be),
    .last_be_o  (last_be),
    .dw_cnt_o   (dw_cnt),
    .is_read_o  (is_read),
    .is_write_o (is_write),
    .is_4dw_o   (is_4dw)
  );

  always_comb begin
    can_load = !tvalid_q || s_axis_rq_tready_a[0];
    if (state_q == StDrop)       in_ready = 1'b1;
    else if (state_q == StFlush) in_ready = 1'b0;
    else                         in_ready = can_load;
    in_fire  = s_axis_rq_tvalid && in_ready;
    rem_next = (rem_q >= 11'd4) ? rem_q - 11'd4 : 11'd0;

    state_d  = state_q;
    rem_d    = rem_q;
    carry_d  = carry_q;
    tdata_d  = tdata_q;
    tkeep_d  = tkeep_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    tvalid_d = tvalid_q && !s_axis_rq_tready_a[0];

    case (state_q)
      StHdr: begin
        if (in_fire) begin
          if (is_read || is_write) begin
            tvalid_d = 1'b1;
            tdata_d  = desc;
            tkeep_d  = 4'hF;
            tlast_d  = is_read;
            tuser_d  = {52'b0, last_be, first_be};
          end
          if (is_write) begin
            rem_d = dw_cnt;
            if (is_4dw) begin
              state_d = StPass;
            end else begin
              carry_d = s_axis_rq_tdata[127:96];
              state_d = s_axis_rq_tlast ? StFlush : StShift;
            end
          end else if (!is_read && !s_axis_rq_tlast) begin
            state_d = StDrop;
          end
        end
      end
      StPass: begin
        if (in_fire) begin
          tvalid_d = 1'b1;
          tdata_d  = s_axis_rq_tdata;
          tkeep_d  = dw_keep(rem_q);
          tlast_d  = (rem_q <= 11'd4);
          tuser_d  = '0;
          rem_d    = rem_next;
          if (s_axis_rq_tlast) state_d = StHdr;
        end
      end
      StShift: begin
        if (in_fire) begin
          tvalid_d = 1'b1;
          tdata_d  = {s_axis_rq_tdata[95:0], carry_q};
          tkeep_d  = dw_keep(rem_q);
          tlast_d  = (rem_q <= 11'd4);
          tuser_d  = '0;
          rem_d    = rem_next;
          carry_d  = s_axis_rq_tdata[127:96];
          // rem keeps L's low bits, so 01 means one DW is still held in carry.
          if (s_axis_rq_tlast) state_d = (rem_q[1:0] == 2'b01) ? StFlush : StHdr;
        end
      end
      StFlush: begin
        if (can_load) begin
          tvalid_d = 1'b1;
          tdata_d  = {96'b0, carry_q};
          tkeep_d  = dw_keep(rem_q);
          tlast_d  = (rem_q <= 11'd4);
          tuser_d  = '0;
          rem_d    = rem_next;
          state_d  = StHdr;
        end
      end
      StDrop: begin
        if (in_fire && s_axis_rq_tlast) state_d = StHdr;
      end
      default: state_d = StHdr;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (user_reset) begin
      state_q  <= StHdr;
      rem_q    <= '0;
      carry_q  <= '0;
      tdata_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= '0;
      tvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      carry_q  <= carry_d;
      tdata_q  <= tdata_d;
      tkeep_q  <= tkeep_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      tvalid_q <= tvalid_d;
    end
  end

  assign s_axis_rq_tready   = in_ready;
  assign s_axis_rq_tdata_a  = tdata_q;
  assign s_axis_rq_tkeep_a  = tkeep_q;
  assign s_axis_rq_tlast_a  = tlast_q;
  assign s_axis_rq_tuser_a  = tuser_q;
  assign s_axis_rq_tvalid_a = tvalid_q;

  logic unused_in;
  assign unused_in = ^{s_axis_rq_tkeep, s_axis_rq_tready_a[3:1]};

endmodule

// File: tb/tb_s_axis_rq_adapt.sv
// Directed-vector bench for s_axis_rq_adapt with hand-computed RQ beats.
module tb_s_axis_rq_adapt;

  localparam int MaxCyc = 2000;

  logic         user_clk = 1'b0;
  logic         user_reset;
  logic [127:0] s_axis_rq_tdata;
  logic [15:0]  s_axis_rq_tkeep;
  logic         s_axis_rq_tlast;
  logic         s_axis_rq_tready;
  logic         s_axis_rq_tvalid;
  logic [127:0] s_axis_rq_tdata_a;
  logic [3:0]   s_axis_rq_tkeep_a;
  logic         s_axis_rq_tlast_a;
  logic [3:0]   s_axis_rq_tready_a;
  logic [59:0]  s_axis_rq_tuser_a;
  logic         s_axis_rq_tvalid_a;

  s_axis_rq_adapt dut (
    .user_clk           (user_clk),
    .user_reset         (user_reset),
    .s_axis_rq_tdata    (s_axis_rq_tdata),
    .s_axis_rq_tkeep    (s_axis_rq_tkeep),
    .s_axis_rq_tlast    (s_axis_rq_tlast),
    .s_axis_rq_tready   (s_axis_rq_tready),
    .s_axis_rq_tvalid   (s_axis_rq_tvalid),
    .s_axis_rq_tdata_a  (s_axis_rq_tdata_a),
    .s_axis_rq_tkeep_a  (s_axis_rq_tkeep_a),
    .s_axis_rq_tlast_a  (s_axis_rq_tlast_a),
    .s_axis_rq_tready_a (s_axis_rq_tready_a),
    .s_axis_rq_tuser_a  (s_axis_rq_tuser_a),
    .s_axis_rq_tvalid_a (s_axis_rq_tvalid_a)
  );

  always #5 user_clk = ~user_clk;

  int n_vec  = 0;
  int n_miss = 0;
  int ready_lo;

  logic [128:0] in_q[$];
  logic [199:0] out_q[$];
  logic [199:0] exp_q[$];

  task automatic check(input string tag, input logic [199:0] got, input logic [199:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [128:0] ib(input logic last, input logic [31:0] d3, input logic [31:0] d2,
                                      input logic [31:0] d1, input logic [31:0] d0);
    return {last, d3, d2, d1, d0};
  endfunction

  function automatic logic [199:0] ob(input logic [7:0] user, input logic last, input logic [3:0] keep,
                                      input logic [31:0] d3, input logic [31:0] d2,
                                      input logic [31:0] d1, input logic [31:0] d0);
    return {7'b0, 52'b0, user, last, keep, d3, d2, d1, d0};
  endfunction

  // Feeds in_q and captures every output handshake; toggle gives tready_a 1010...
  task automatic run(input bit toggle);
    int idx;
    int cyc;
    int idle;
    logic [128:0] b;
    idx = 0;
    cyc = 0;
    idle = 0;
    ready_lo = 0;
    while ((idx < in_q.size() || idle < 8) && cyc < MaxCyc) begin
      @(negedge user_clk);
      if (toggle) s_axis_rq_tready_a = cyc[0] ? 4'hE : 4'h1;
      else        s_axis_rq_tready_a = 4'hF;
      if (idx < in_q.size()) begin
        b = in_q[idx];
        s_axis_rq_tvalid = 1'b1;
        s_axis_rq_tdata  = b[127:0];
        s_axis_rq_tlast  = b[128];
      end else begin
        s_axis_rq_tvalid = 1'b0;
        s_axis_rq_tdata  = '0;
        s_axis_rq_tlast  = 1'b0;
      end
      #1;
      if (!s_axis_rq_tready) ready_lo++;
      if (s_axis_rq_tvalid_a && s_axis_rq_tready_a[0])
        out_q.push_back({7'b0, s_axis_rq_tuser_a, s_axis_rq_tlast_a, s_axis_rq_tkeep_a,
                         s_axis_rq_tdata_a});
      if (s_axis_rq_tvalid && s_axis_rq_tready) idx++;
      if (idx >= in_q.size()) idle++;
      cyc++;
    end
    check("timeout", 200'(cyc >= MaxCyc), 200'(0));
  endtask

  task automatic compare_out(input string tag);
    check({tag, "_nbeats"}, 200'(out_q.size()), 200'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < out_q.size()) check($sformatf("%s_b%0d", tag, i), out_q[i], exp_q[i]);
    end
    out_q.delete();
    exp_q.delete();
    in_q.delete();
  endtask

  task automatic load_mrd;
    in_q.push_back(ib(1'b1, 32'h0, 32'h12345678, 32'h01002AFF, 32'h00000010));
    exp_q.push_back(ob(8'hFF, 1'b1, 4'hF, 32'h0100002A, 32'h01000010, 32'h0, 32'h12345678));
  endtask

  task automatic load_l9;
    in_q.push_back(ib(1'b0, 32'd1, 32'h00000040, 32'h000000FF, 32'h40000009));
    in_q.push_back(ib(1'b0, 32'd5, 32'd4, 32'd3, 32'd2));
    in_q.push_back(ib(1'b1, 32'd9, 32'd8, 32'd7, 32'd6));
    exp_q.push_back(ob(8'hFF, 1'b0, 4'hF, 32'h01000000, 32'h00000809, 32'h0, 32'h00000040));
    exp_q.push_back(ob(8'h00, 1'b0, 4'hF, 32'd4, 32'd3, 32'd2, 32'd1));
    exp_q.push_back(ob(8'h00, 1'b0, 4'hF, 32'd8, 32'd7, 32'd6, 32'd5));
    exp_q.push_back(ob(8'h00, 1'b1, 4'h1, 32'd0, 32'd0, 32'd0, 32'd9));
  endtask

  initial begin
    user_reset         = 1'b1;
    s_axis_rq_tdata    = '0;
    s_axis_rq_tkeep    = '1;
    s_axis_rq_tlast    = 1'b0;
    s_axis_rq_tvalid   = 1'b0;
    s_axis_rq_tready_a = 4'hF;
    repeat (3) @(negedge user_clk);
    check("rst_tvalid", 200'(s_axis_rq_tvalid_a), 200'(0));
    check("rst_tdata", 200'(s_axis_rq_tdata_a), 200'(0));
    check("rst_tkeep", 200'(s_axis_rq_tkeep_a), 200'(0));
    check("rst_tlast", 200'(s_axis_rq_tlast_a), 200'(0));
    check("rst_tuser", 200'(s_axis_rq_tuser_a), 200'(0));
    check("rst_tready", 200'(s_axis_rq_tready), 200'(1));
    user_reset = 1'b0;

    // MRd 3DW
    load_mrd();
    run(1'b0);
    compare_out("mrd3");

    // MWr 3DW, L=1: descriptor then a flush beat, one input bubble
    in_q.push_back(ib(1'b1, 32'hCAFEBABE, 32'h00001000, 32'h0100000F, 32'h40000001));
    exp_q.push_back(ob(8'h0F, 1'b0, 4'hF, 32'h01000000, 32'h01000801, 32'h0, 32'h00001000));
    exp_q.push_back(ob(8'h00, 1'b1, 4'h1, 32'h0, 32'h0, 32'h0, 32'hCAFEBABE));
    run(1'b0);
    check("l1_bubble", 200'(ready_lo), 200'(1));
    compare_out("mwr3_l1");

    // MWr 3DW, L=4: no flush
    in_q.push_back(ib(1'b0, 32'd1, 32'h20000000, 32'h010001FF, 32'h40000004));
    in_q.push_back(ib(1'b1, 32'h0, 32'd4, 32'd3, 32'd2));
    exp_q.push_back(ob(8'hFF, 1'b0, 4'hF, 32'h01000001, 32'h01000804, 32'h0, 32'h20000000));
    exp_q.push_back(ob(8'h00, 1'b1, 4'hF, 32'd4, 32'd3, 32'd2, 32'd1));
    run(1'b0);
    check("l4_bubble", 200'(ready_lo), 200'(0));
    compare_out("mwr3_l4");

    // MWr 4DW, L=6, with TC=3, attr=2, EP set
    in_q.push_back(ib(1'b0, 32'h80000004, 32'h00000001, 32'hABCD05F3, 32'h60306006));
    in_q.push_back(ib(1'b0, 32'h13, 32'h12, 32'h11, 32'h10));
    in_q.push_back(ib(1'b1, 32'h0, 32'h0, 32'h15, 32'h14));
    exp_q.push_back(ob(8'hF3, 1'b0, 4'hF, 32'h27000005, 32'hABCD8806, 32'h00000001, 32'h80000004));
    exp_q.push_back(ob(8'h00, 1'b0, 4'hF, 32'h13, 32'h12, 32'h11, 32'h10));
    exp_q.push_back(ob(8'h00, 1'b1, 4'h3, 32'h0, 32'h0, 32'h15, 32'h14));
    run(1'b0);
    compare_out("mwr4_l6");

    // L=9 3DW without and with output backpressure
    load_l9();
    run(1'b0);
    compare_out("l9_free");
    load_l9();
    run(1'b1);
    compare_out("l9_bp");

    // CfgRd0 is dropped, following MRd still converts
    in_q.push_back(ib(1'b0, 32'h0, 32'h00000010, 32'h0100010F, 32'h04000001));
    in_q.push_back(ib(1'b1, 32'h40000001, 32'h12345678, 32'h01002AFF, 32'h00000010));
    load_mrd();
    run(1'b0);
    compare_out("drop");

    // Reset in the middle of a SHIFT packet
    in_q.push_back(ib(1'b0, 32'd1, 32'h00000040, 32'h000000FF, 32'h40000009));
    in_q.push_back(ib(1'b0, 32'd5, 32'd4, 32'd3, 32'd2));
    exp_q.push_back(ob(8'hFF, 1'b0, 4'hF, 32'h01000000, 32'h00000809, 32'h0, 32'h00000040));
    exp_q.push_back(ob(8'h00, 1'b0, 4'hF, 32'd4, 32'd3, 32'd2, 32'd1));
    run(1'b0);
    compare_out("pre_rst");
    @(negedge user_clk);
    s_axis_rq_tready_a = 4'h0;
    s_axis_rq_tvalid   = 1'b1;
    s_axis_rq_tdata    = {32'd9, 32'd8, 32'd7, 32'd6};
    s_axis_rq_tlast    = 1'b0;
    @(negedge user_clk);
    check("mid_held_valid", 200'(s_axis_rq_tvalid_a), 200'(1));
    s_axis_rq_tvalid = 1'b0;
    user_reset       = 1'b1;
    @(negedge user_clk);
    check("mid_rst_tvalid", 200'(s_axis_rq_tvalid_a), 200'(0));
    check("mid_rst_tlast", 200'(s_axis_rq_tlast_a), 200'(0));
    check("mid_rst_tready", 200'(s_axis_rq_tready), 200'(1));
    user_reset         = 1'b0;
    s_axis_rq_tready_a = 4'hF;
    load_mrd();
    run(1'b0);
    compare_out("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
